// File: rtl/nes_joypad_responder.sv
// NES controller emulator: answers the console's joypad latch/clock protocol
// with debounced board buttons, behaving like a 4021 parallel-in/serial-out
// shifter. The serial line is active-low: 0 means pressed.
module nes_joypad_responder #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk_in,
    input  logic       nres_in,
    input  logic [7:0] btn_in,
    input  logic       jp_latch_in,
    input  logic       jp_clk_in,
    output logic       jp_data_out,
    output logic [7:0] btn_state_out,
    output logic [3:0] bit_cnt_out
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchronizer chains; the last stage is the synced value.
    logic [SYNC_STAGES-1:0]      latch_sync_q;
    logic [SYNC_STAGES-1:0]      clk_sync_q;
    logic [SYNC_STAGES-1:0][7:0] btn_sync_q;
    logic                        clk_prev_q;

    logic       latch_synced_s;
    logic       clk_synced_s;
    logic [7:0] btn_synced_s;
    logic       clk_rise_s;

    // Debounce state.
    logic [7:0][CNT_W-1:0] bounce_cnt_q;
    logic [7:0][CNT_W-1:0] bounce_cnt_d;
    logic [7:0]            btn_state_q;
    logic [7:0]            btn_state_d;

    // Shifter state.
    logic [7:0] sr_q;
    logic [7:0] sr_d;
    logic [3:0] bit_cnt_q;
    logic [3:0] bit_cnt_d;

    assign latch_synced_s = latch_sync_q[SYNC_STAGES-1];
    assign clk_synced_s   = clk_sync_q[SYNC_STAGES-1];
    assign btn_synced_s   = btn_sync_q[SYNC_STAGES-1];
    assign clk_rise_s     = clk_synced_s & ~clk_prev_q;

    // Bring the asynchronous pins into the clk_in domain and keep the previous
    // synced joypad clock for rising-edge detection.
    always_ff @(posedge clk_in or negedge nres_in) begin
        if (!nres_in) begin
            latch_sync_q <= '0;
            clk_sync_q   <= '0;
            btn_sync_q   <= '0;
            clk_prev_q   <= 1'b0;
        end else begin
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], jp_latch_in};
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], jp_clk_in};
            btn_sync_q   <= {btn_sync_q[SYNC_STAGES-2:0], btn_in};
            clk_prev_q   <= clk_synced_s;
        end
    end

    // Per-button debounce: a disagreeing input must persist DEBOUNCE_CYCLES
    // consecutive cycles before the stable state flips; any agreement restarts it.
    always_comb begin
        bounce_cnt_d = bounce_cnt_q;
        btn_state_d  = btn_state_q;
        for (int i = 0; i < 8; i++) begin
            if (btn_synced_s[i] == btn_state_q[i]) begin
                bounce_cnt_d[i] = '0;
            end else if (bounce_cnt_q[i] == CNT_LAST) begin
                bounce_cnt_d[i] = '0;
                btn_state_d[i]  = ~btn_state_q[i];
            end else begin
                bounce_cnt_d[i] = bounce_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Debounce registers.
    always_ff @(posedge clk_in or negedge nres_in) begin
        if (!nres_in) begin
            bounce_cnt_q <= '0;
            btn_state_q  <= 8'h00;
        end else begin
            bounce_cnt_q <= bounce_cnt_d;
            btn_state_q  <= btn_state_d;
        end
    end

    // Shifter next state: latch keeps reloading (and masks clock edges);
    // each clock edge shifts a pressed level in so overrun reads return 0.
    always_comb begin
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        if (latch_synced_s) begin
            sr_d      = btn_state_q;
            bit_cnt_d = 4'd0;
        end else if (clk_rise_s) begin
            sr_d = {1'b1, sr_q[7:1]};
            if (bit_cnt_q >= 4'd8) begin
                bit_cnt_d = 4'd8;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else begin
            sr_d      = sr_q;
            bit_cnt_d = bit_cnt_q;
        end
    end

    // Shifter registers; the serial line is taken straight from sr_q[0].
    always_ff @(posedge clk_in or negedge nres_in) begin
        if (!nres_in) begin
            sr_q      <= 8'h00;
            bit_cnt_q <= 4'd0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign jp_data_out   = ~sr_q[0];
    assign btn_state_out = btn_state_q;
    assign bit_cnt_out   = bit_cnt_q;

endmodule

// File: tb/tb_nes_joypad_responder.sv
// Scoreboard bench for nes_joypad_responder: stimulus pushes timed expectations
// derived from a read-index model of the controller; a monitor on the falling
// clock edge pops and compares them.
module tb_nes_joypad_responder;

    localparam int DEB  = 4;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 1;

    logic       clk = 1'b0;
    logic       nres_in;
    logic [7:0] btn_in;
    logic       jp_latch_in;
    logic       jp_clk_in;
    logic       jp_data_out;
    logic [7:0] btn_state_out;
    logic [3:0] bit_cnt_out;

    nes_joypad_responder #(.DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
        .clk_in       (clk),
        .nres_in      (nres_in),
        .btn_in       (btn_in),
        .jp_latch_in  (jp_latch_in),
        .jp_clk_in    (jp_clk_in),
        .jp_data_out  (jp_data_out),
        .btn_state_out(btn_state_out),
        .bit_cnt_out  (bit_cnt_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        bit           is_btn;
        logic         d;
        logic [3:0]   cnt;
        logic [7:0]   bs;
        bit [8*8-1:0] name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model: buttons as the console should see them.
    logic [7:0] bs_model;    // settled debounced buttons
    logic [7:0] lv_model;    // value captured by the last latch
    int         k_model;     // reads since that latch
    bit         latch_high;

    function automatic logic exp_bit(input logic [7:0] v, input int k);
        if (k < 8) return ~v[k];
        return 1'b0;
    endfunction

    function automatic logic [3:0] sat8(input int k);
        return (k > 8) ? 4'd8 : 4'(k);
    endfunction

    task automatic push_line(input int c, input logic d, input logic [3:0] cnt, input bit [8*8-1:0] nm);
        exp_t e;
        e.cyc = c; e.is_btn = 1'b0; e.d = d; e.cnt = cnt; e.bs = 8'h00; e.name = nm;
        q.push_back(e);
    endtask

    task automatic push_btn(input int c, input logic [7:0] bs, input bit [8*8-1:0] nm);
        exp_t e;
        e.cyc = c; e.is_btn = 1'b1; e.d = 1'b0; e.cnt = 4'd0; e.bs = bs; e.name = nm;
        q.push_back(e);
    endtask

    // Monitor: compare every expectation scheduled for this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (e.cyc < cyc) begin
                n_err++;
                $display("FAIL %0s missed: expectation for cycle %0d not checked (now %0d)", e.name, e.cyc, cyc);
            end else if (e.is_btn) begin
                if (btn_state_out !== e.bs) begin
                    n_err++;
                    $display("FAIL %0s cyc %0d: btn_state_out=%h expected %h", e.name, cyc, btn_state_out, e.bs);
                end
            end else begin
                if (jp_data_out !== e.d || bit_cnt_out !== e.cnt) begin
                    n_err++;
                    $display("FAIL %0s cyc %0d: data=%b cnt=%0d expected data=%b cnt=%0d",
                             e.name, cyc, jp_data_out, bit_cnt_out, e.d, e.cnt);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_buttons(input logic [7:0] v);
        btn_in = v;
        tick(SYNC + DEB + 4);
        bs_model = v;
        push_btn(cyc + 1, bs_model, "btnset");
    endtask

    task automatic latch_pulse();
        push_line(cyc + LAT, ~bs_model[0], 4'd0, "latch");
        jp_latch_in = 1'b1;
        tick(4);
        jp_latch_in = 1'b0;
        tick(4);
        lv_model = bs_model;
        k_model  = 0;
    endtask

    task automatic clk_pulse(input int hi, input int lo);
        if (latch_high) begin
            push_line(cyc + LAT, ~bs_model[0], 4'd0, "latchpri");
        end else begin
            push_line(cyc + LAT - 1, exp_bit(lv_model, k_model), sat8(k_model), "preshift");
            k_model++;
            push_line(cyc + LAT, exp_bit(lv_model, k_model), sat8(k_model), "shift");
        end
        jp_clk_in = 1'b1;
        tick(hi);
        jp_clk_in = 1'b0;
        tick(lo);
    endtask

    initial begin
        int c;
        nres_in = 1'b0; btn_in = 8'hFF; jp_latch_in = 1'b0; jp_clk_in = 1'b0;
        bs_model = 8'h00; lv_model = 8'h00; k_model = 0; latch_high = 1'b0;

        // Held in reset with buttons pressed and the clock toggling.
        for (int i = 0; i < 10; i++) begin
            push_line(cyc + 1, 1'b1, 4'd0, "rsthold");
            push_btn(cyc + 1, 8'h00, "rstbtn");
            jp_clk_in = ~jp_clk_in;
            tick(1);
        end
        btn_in = 8'h00; jp_clk_in = 1'b0;
        tick(2);
        nres_in = 1'b1;
        tick(4);

        // Glitch of DEB-1 cycles on A never reaches the debounced state.
        c = cyc;
        for (int i = 1; i <= 10; i++) push_btn(c + i, 8'h00, "glitch");
        btn_in = 8'h01;
        tick(DEB - 1);
        btn_in = 8'h00;
        tick(10);

        // Held press appears exactly SYNC+DEB cycles after the edge.
        c = cyc;
        push_btn(c + SYNC + DEB - 1, 8'h00, "debearly");
        push_btn(c + SYNC + DEB, 8'h01, "debedge");
        btn_in = 8'h01;
        tick(10);
        bs_model = 8'h01;

        // Full read of A+Select+Right with overrun.
        set_buttons(8'h85);
        latch_pulse();
        for (int i = 0; i < 12; i++) clk_pulse(4, 4);

        // Latch held high masks clock edges and tracks button changes.
        set_buttons(8'h3C);
        push_line(cyc + LAT, 1'b1, 4'd0, "latchhi");
        jp_latch_in = 1'b1;
        latch_high  = 1'b1;
        tick(4);
        for (int i = 0; i < 3; i++) clk_pulse(4, 4);
        c = cyc;
        push_btn(c + SYNC + DEB - 1, 8'h3C, "lbtnold");
        push_btn(c + SYNC + DEB, 8'h3D, "lbtnnew");
        push_line(c + SYNC + DEB, 1'b1, 4'd0, "lineold");
        push_line(c + SYNC + DEB + 1, 1'b0, 4'd0, "linenew");
        btn_in = 8'h3D;
        tick(12);
        bs_model = 8'h3D;
        jp_latch_in = 1'b0;
        latch_high  = 1'b0;
        tick(4);
        lv_model = 8'h3D;
        k_model  = 0;
        for (int i = 0; i < 3; i++) clk_pulse(4, 4);

        // Randomized reads with random pulse widths.
        for (int r = 0; r < 8; r++) begin
            set_buttons(8'($urandom));
            latch_pulse();
            for (int i = 0; i < int'($urandom_range(1, 12)); i++)
                clk_pulse(int'($urandom_range(3, 7)), int'($urandom_range(3, 7)));
        end

        // Reset in the middle of shifting out 8'hFF.
        set_buttons(8'hFF);
        latch_pulse();
        for (int i = 0; i < 3; i++) clk_pulse(4, 4);
        @(posedge clk);
        #1;
        nres_in = 1'b0;
        push_line(cyc, 1'b1, 4'd0, "rstasync");
        push_btn(cyc, 8'h00, "rstabtn");
        tick(3);
        nres_in  = 1'b1;
        bs_model = 8'h00;
        tick(2);
        set_buttons(8'hFF);
        latch_pulse();
        for (int i = 0; i < 8; i++) clk_pulse(4, 4);

        tick(10);
        if (q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/nes_joypad_responder.md
Name: nes_joypad_responder

Overview:
- Emulates a standard NES controller (4021-style parallel-in/serial-out shifter) on the console-side joypad cable: NES_JOYPAD_LATCH, NES_JOYPAD_CLK and NES_JOYPAD_DATAx.
- It is the responding end of the joypad protocol that the rp2a03 joypad logic initiates.
- Button inputs come from board pushbuttons or switches. They are synchronized, debounced, latched on the latch pulse, and shifted out one bit per joypad clock edge.
- Used for controller-less bring-up and loopback testing of the rp2a03 joypad path.

Parameters:
- DEBOUNCE_CYCLES, 100000: consecutive stable clk_in cycles a synced button must hold before its debounced state changes. 1 ms at 100 MHz. Must be >= 1.
- SYNC_STAGES, 2: flip-flop depth of the input synchronizers for jp_latch_in, jp_clk_in and btn_in. Must be >= 2.

Ports:
- clk_in, input, 1: system clock (100 MHz).
- nres_in, input, 1: asynchronous, active-low reset.
- btn_in, input, 8: raw buttons, active-high, asynchronous. Bit 0 = A, 1 = B, 2 = Select, 3 = Start, 4 = Up, 5 = Down, 6 = Left, 7 = Right.
- jp_latch_in, input, 1: joypad latch from the console, asynchronous.
- jp_clk_in, input, 1: joypad clock from the console, asynchronous.
- jp_data_out, output, 1: serial data to the console, active-low (0 = pressed).
- btn_state_out, output, 8: debounced button state, active-high.
- bit_cnt_out, output, 4: shifts since the last latch, saturating at 8.

Behaviour:
- Reset (nres_in = 0, asynchronous):
  - all synchronizer flops = 0;
  - debounce counters = 0 and btn_state_out = 8'h00;
  - shift register = 8'h00, so jp_data_out = 1 (released);
  - bit_cnt_out = 0.
  - Reset asserted mid-shift aborts the shift immediately. Outputs return to reset values within the same cycle (asynchronous).
- Synchronizers: btn_in[7:0], jp_latch_in and jp_clk_in each pass through SYNC_STAGES flops. A clock-edge detector registers the synced jp_clk one more time; clk_rise = synced & ~prev.
- Debounce, independent per button:
  - if synced bit == btn_state bit, its counter clears;
  - otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the state bit toggles and the counter clears.
  - Counter width = clog2(DEBOUNCE_CYCLES) (minimum 1).
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_state_out.
- Shift register sr[7:0] holds active-high pressed bits; jp_data_out = ~sr[0].
  - Load: while synced latch = 1, sr <= btn_state_out every cycle and bit_cnt <= 0. Load has priority over a simultaneous clk_rise, which is ignored.
  - Shift: on clk_rise with synced latch = 0, sr <= {1'b1, sr[7:1]} and bit_cnt <= min(bit_cnt+1, 8).
  - After 8 shifts the line reads 0 (pressed level) indefinitely, matching official controllers, which return 1 in $4016 bit 0 after 8 reads.
  - On latch falling, sr holds the last loaded value. No further load occurs until latch rises again.
- Latency:
  - jp_latch_in or jp_clk_in pin edge to jp_data_out change = SYNC_STAGES+1 clk_in cycles (3 by default).
  - btn_in edge to btn_state_out change = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Timing constraint: pulses on jp_clk_in / jp_latch_in (high and low phases) must each last >= SYNC_STAGES+1 clk_in cycles. Shorter pulses may be missed. The NES CPU clock period is ~56 clk_in cycles, so real traffic always meets this.
- jp_data_out is registered (driven from the sr flop through a single inverter), so it is glitch-free.

Test Plan:
- Reset: hold nres_in = 0 with btn_in = 8'hFF and toggling jp_clk_in -> jp_data_out = 1, btn_state_out = 8'h00, bit_cnt_out = 0 throughout.
- Debounce (DEBOUNCE_CYCLES = 4):
  - btn_in[0] high for 3 cycles, then low -> btn_state_out stays 8'h00;
  - btn_in[0] held high -> btn_state_out = 8'h01 exactly SYNC_STAGES+4 cycles after the edge.
- Full read: btn_state = 8'b1000_0101 (A, Select, Right), latch pulse, then 8 clk pulses -> jp_data_out sequence = 0,1,0,1,1,1,1,0. bit_cnt_out steps 1..8. Data changes 3 cycles after each jp_clk_in rise.
- Overrun: 4 additional clk pulses after 8 -> jp_data_out = 0 on each; bit_cnt_out saturates at 8.
- Latch priority:
  - hold latch high while pulsing jp_clk_in -> jp_data_out stays ~btn_state[0], bit_cnt_out = 0;
  - change a button while latch is high -> the new state appears on the line after debounce.
- Reset mid-shift: after 3 shifts of 8'hFF assert nres_in -> jp_data_out = 1 immediately; after release, latch + 8 clks returns 8'hFF cleanly (all 0s on the line).
